// File: rtl/frame_swap_sequencer.sv
// Frame swap sequencer: runs N_CHAN writer channels through start/done handshakes in index
// order, then a display swap. Optional watchdog: FRAME_SWAP_SEQUENCER_TIMEOUT_EN.
module frame_swap_sequencer #(
  parameter int N_CHAN         = 2,
  parameter int FRAME_CNT_W    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [N_CHAN-1:0]      chan_en,
  output logic [N_CHAN-1:0]      start,
  input  logic [N_CHAN-1:0]      start_ack,
  input  logic [N_CHAN-1:0]      done,
  output logic [N_CHAN-1:0]      done_ack,
  output logic                   swap,
  input  logic                   swap_ack,
  output logic                   busy,
  output logic [3:0]             active_chan,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_START, S_WAIT_DONE, S_DONE_ACK, S_SWAP, S_SWAP_REL
  } state_t;

  state_t                 state, state_n;
  logic [N_CHAN-1:0]      mask, mask_n;
  logic [3:0]             chan_n;
  logic [FRAME_CNT_W-1:0] fcnt_n;
  logic [N_CHAN-1:0]      chan_oh;
  logic                   sel_en, sel_ack, sel_done, last, abort;
  logic [N_CHAN-1:0]      start_n, done_ack_n;
  logic                   swap_n, busy_n;

  // Only the active channel's inputs are ever looked at.
  assign chan_oh  = N_CHAN'(1) << active_chan;
  assign sel_en   = |(mask & chan_oh);
  assign sel_ack  = |(start_ack & chan_oh);
  assign sel_done = |(done & chan_oh);
  assign last     = (active_chan == 4'(N_CHAN - 1));

  always_comb begin
    state_n = state;
    chan_n  = active_chan;
    mask_n  = mask;
    fcnt_n  = frame_count;
    case (state)
      S_IDLE: begin
        if (run) begin
          mask_n  = chan_en;
          chan_n  = 4'd0;
          state_n = S_SEL;
        end
      end
      S_SEL: begin
        if (sel_en)    state_n = S_START;
        else if (last) state_n = S_SWAP;
        else           chan_n  = active_chan + 4'd1;
      end
      S_START:     if (sel_ack)  state_n = S_WAIT_DONE;
      S_WAIT_DONE: if (sel_done) state_n = S_DONE_ACK;
      S_DONE_ACK: begin
        if (!sel_done) begin
          if (last) state_n = S_SWAP;
          else begin
            chan_n  = active_chan + 4'd1;
            state_n = S_SEL;
          end
        end
      end
      S_SWAP: begin
        if (swap_ack) begin
          fcnt_n  = frame_count + FRAME_CNT_W'(1);
          state_n = S_SWAP_REL;
        end
      end
      S_SWAP_REL: begin
        if (!swap_ack) begin
          if (run) begin
            mask_n  = chan_en;
            chan_n  = 4'd0;
            state_n = S_SEL;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Watchdog abort overrides whatever the handshake would have done this cycle.
    if (abort) begin
      state_n = S_IDLE;
      chan_n  = active_chan;
      mask_n  = mask;
      fcnt_n  = frame_count;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    start_n    = (state_n == S_START)    ? (N_CHAN'(1) << chan_n) : '0;
    done_ack_n = (state_n == S_DONE_ACK) ? (N_CHAN'(1) << chan_n) : '0;
    swap_n     = (state_n == S_SWAP);
    busy_n     = (state_n != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      mask        <= '0;
      active_chan <= 4'd0;
      frame_count <= '0;
      start       <= '0;
      done_ack    <= '0;
      swap        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      mask        <= mask_n;
      active_chan <= chan_n;
      frame_count <= fcnt_n;
      start       <= start_n;
      done_ack    <= done_ack_n;
      swap        <= swap_n;
      busy        <= busy_n;
    end
  end

`ifdef FRAME_SWAP_SEQUENCER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_on, err_q;

  assign wd_on = state inside {S_START, S_WAIT_DONE, S_DONE_ACK, S_SWAP, S_SWAP_REL};
  assign abort = wd_on && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_n != state) wd_cnt <= '0;
      else if (wd_on)       wd_cnt <= wd_cnt + WD_W'(1);
      if (abort)            err_q  <= 1'b1;
    end
  end

  assign error = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign abort = 1'b0;
  assign error = 1'b0;
`endif

endmodule
